// File: rtl/accum_drain.sv
// accum_drain: readout end of the accumulator bank.
// A start pulse snapshots all LANES accumulator values, which are then
// streamed one lane per beat over valid/ready, followed by a one-cycle
// acc_clear pulse back to the accumulators.
// Optional build macro: ACCUM_DRAIN_SAT_EN -- signed saturation of each lane
// to OUT_WIDTH instead of plain truncation.

// Per-lane shadow register plus width conversion.
module accum_drain_lane #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap,
  input  logic [WIDTH-1:0]     acc,
  output logic [OUT_WIDTH-1:0] conv
);

`ifdef ACCUM_DRAIN_SAT_EN
  logic [WIDTH-1:0] shadow_d, shadow_q;
  logic [WIDTH-OUT_WIDTH:0] top_bits;
  logic fits;

  // Load the snapshot on capture, otherwise hold.
  always_comb begin
    shadow_d = shadow_q;
    if (cap) shadow_d = acc;
  end

  // Shadow register, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  // Value fits the signed output range when every bit from the output sign
  // position upward matches the input sign.
  always_comb begin
    top_bits = shadow_q[WIDTH-1:OUT_WIDTH-1];
    fits     = (&top_bits) | ~(|top_bits);
    if (fits)               conv = shadow_q[OUT_WIDTH-1:0];
    else if (shadow_q[WIDTH-1]) conv = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                    conv = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
`else
  // Only the low bits reach the output, so only those are stored.
  logic [OUT_WIDTH-1:0] shadow_d, shadow_q;

  // Load the snapshot on capture, otherwise hold.
  always_comb begin
    shadow_d = shadow_q;
    if (cap) shadow_d = acc[OUT_WIDTH-1:0];
  end

  // Shadow register, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  assign conv = shadow_q;

  if (OUT_WIDTH < WIDTH) begin : g_drop
    logic unused_hi;
    assign unused_hi = ^acc[WIDTH-1:OUT_WIDTH];
  end
`endif

endmodule

module accum_drain #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int OUT_WIDTH = 16,
  localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LANES*WIDTH-1:0] acc_in,
  output logic                   busy,
  output logic                   acc_clear,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [LW-1:0]          out_lane,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [1:0]    state_d, state_q;
  logic [LW-1:0] lane_d, lane_q;
  logic          cap;
  logic          is_last;
  logic [OUT_WIDTH-1:0] sel_data;

  logic [LANES-1:0][WIDTH-1:0]     acc_lanes;
  logic [LANES-1:0][OUT_WIDTH-1:0] lane_conv;

  assign acc_lanes = acc_in;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    accum_drain_lane #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .cap   (cap),
      .acc   (acc_lanes[i]),
      .conv  (lane_conv[i])
    );
  end

  assign is_last = (lane_q == LAST_LANE);

  // Drain sequencing: capture in IDLE, one lane per handshake, then clear.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cap     = 1'b1;
          lane_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (is_last) begin
            lane_d  = '0;
            state_d = S_CLEAR;
          end else begin
            lane_d  = lane_q + 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; reset aborts a drain without issuing a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Lane select written as a compare loop so any LANES count is safe.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < LANES; i++)
      if (lane_q == LW'(i)) sel_data = lane_conv[i];
  end

  assign out_valid = (state_q == S_SEND);
  assign busy      = (state_q != S_IDLE);
  assign acc_clear = (state_q == S_CLEAR);
  assign out_last  = out_valid & is_last;
  assign out_lane  = out_valid ? lane_q : '0;
  assign out_data  = out_valid ? sel_data : '0;

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain with a beat scoreboard. Expected beats are
// queued when a drain is started and checked by a negedge monitor.
module tb_accum_drain;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int OW    = 16;

  typedef struct {
    logic [OW-1:0] data;
    logic [1:0]    lane;
    logic          last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [LANES*WIDTH-1:0] acc_in;
  logic                   busy, acc_clear, out_valid, out_last, out_ready;
  logic [OW-1:0]          out_data;
  logic [1:0]             out_lane;

  int errs = 0;
  int checks = 0;
  int hs_cnt = 0;
  int clr_cnt = 0;
  beat_t q[$];

  accum_drain #(.WIDTH(WIDTH), .LANES(LANES), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .acc_in    (acc_in),
    .busy      (busy),
    .acc_clear (acc_clear),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] conv(input logic [WIDTH-1:0] v);
`ifdef ACCUM_DRAIN_SAT_EN
    int s;
    s = signed'(v);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return v[OW-1:0];
  endfunction

  task automatic set_acc(input logic [31:0] a0, a1, a2, a3);
    acc_in = {a3, a2, a1, a0};
  endtask

  task automatic push_drain(input logic [31:0] a0, a1, a2, a3);
    logic [31:0] v[4];
    beat_t b;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < 4; i++) begin
      b.data = conv(v[i]);
      b.lane = 2'(i);
      b.last = (i == 3);
      q.push_back(b);
    end
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!busy && q.size() == 0) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Monitor: scoreboard beats, clear timing, stall stability.
  logic prev_last_hs = 0, prev_clear = 0, prev_stall = 0;
  logic [OW-1:0] p_data;
  logic [1:0] p_lane;
  logic p_last;
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      prev_last_hs = 0; prev_clear = 0; prev_stall = 0;
    end else begin
      chk("clear_after_last", 32'(acc_clear), 32'(prev_last_hs));
      if (prev_clear) chk("idle_after_clear", 32'(busy), 32'd0);
      if (prev_stall) begin
        chk("stall_data", 32'(out_data), 32'(p_data));
        chk("stall_lane", 32'(out_lane), 32'(p_lane));
        chk("stall_last", 32'(out_last), 32'(p_last));
      end
      if (!out_valid) chk("lane_idle_zero", 32'(out_lane), 32'd0);
      if (acc_clear) clr_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_lane", 32'(out_lane), 32'(e.lane));
          chk("beat_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_last_hs = out_valid && out_ready && out_last;
      prev_clear   = acc_clear;
      prev_stall   = out_valid && !out_ready;
      p_data = out_data; p_lane = out_lane; p_last = out_last;
    end
  end

  initial begin
    int h0, c0;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; acc_in = '0;

    // Reset and idle
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_clear", 32'(acc_clear), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_lane", 32'(out_lane), 0);
    chk("rst_last", 32'(out_last), 0);
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);

    // Basic drain, back-to-back
    h0 = hs_cnt; c0 = clr_cnt;
    set_acc(10, 20, 30, 40);
    out_ready = 1'b1;
    push_drain(10, 20, 30, 40);
    kick();
    chk("first_valid", 32'(out_valid), 1);
    chk("first_lane", 32'(out_lane), 0);
    chk("first_data", 32'(out_data), 32'(conv(10)));
    chk("busy_in_send", 32'(busy), 1);
    wait_idle("basic_done");
    chk("basic_beats", hs_cnt - h0, 4);
    chk("basic_clears", clr_cnt - c0, 1);

    // Backpressure on lane 1
    h0 = hs_cnt;
    push_drain(10, 20, 30, 40);
    kick();
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("bp_data", 32'(out_data), 32'(conv(20)));
    chk("bp_lane", 32'(out_lane), 1);
    chk("bp_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    wait_idle("bp_done");
    chk("bp_beats", hs_cnt - h0, 4);

    // Snapshot isolation and start ignored while busy
    h0 = hs_cnt; c0 = clr_cnt;
    set_acc(11, 22, 33, 44);
    push_drain(11, 22, 33, 44);
    kick();
    set_acc(99, 99, 99, 99);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("snap_done");
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_second_drain", 32'(busy), 0);
    end
    chk("snap_beats", hs_cnt - h0, 4);
    chk("snap_clears", clr_cnt - c0, 1);

    // Reset mid-drain after lane 1 handshake
    c0 = clr_cnt;
    set_acc(5, 6, 7, 8);
    push_drain(5, 6, 7, 8);
    kick();
    repeat (2) @(posedge clk);
    #1;
    chk("pre_abort_lane", 32'(out_lane), 2);
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_data", 32'(out_data), 0);
    chk("abort_lane", 32'(out_lane), 0);
    chk("abort_clear", 32'(acc_clear), 0);
    q.delete();
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_clear", clr_cnt - c0, 0);
    set_acc(100, 200, 300, 400);
    push_drain(100, 200, 300, 400);
    kick();
    chk("fresh_lane", 32'(out_lane), 0);
    chk("fresh_data", 32'(out_data), 32'(conv(100)));
    wait_idle("fresh_done");

    // Width conversion
    set_acc(32'h0001_2345, -32'sd70000, 32'hFFFF_8000, 32'h0000_8000);
    push_drain(32'h0001_2345, -32'sd70000, 32'hFFFF_8000, 32'h0000_8000);
    out_ready = 1'b0;
    kick();
`ifdef ACCUM_DRAIN_SAT_EN
    chk("conv_pos", 32'(out_data), 32'h7FFF);
`else
    chk("conv_trunc", 32'(out_data), 32'h2345);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
`ifdef ACCUM_DRAIN_SAT_EN
    chk("conv_neg", 32'(out_data), 32'h8000);
`else
    chk("conv_neg_trunc", 32'(out_data), 32'hEE90);
`endif
    wait_idle("conv_done");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/accum_drain.md
Name: accum_drain

Overview:
- Readout end of the accumulator bank.
- On a start pulse, snapshots LANES accumulator outputs in parallel, then streams them one per beat over a valid/ready interface.
- After the last beat, pulses a clear back to the accumulators.
- Sits between the accumulator array and the output buffer/writeback path.

Parameters:
- WIDTH, 32, bit width of each accumulator lane input.
- LANES, 4, number of accumulator lanes captured per drain (>=1).
- OUT_WIDTH, 16, bit width of each output beat (<= WIDTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- start  input  1  request a drain; sampled only in IDLE.
- acc_in  input  LANES*WIDTH  packed accumulator values; lane i = acc_in[i*WIDTH +: WIDTH], two's complement.
- busy  output  1  high in every state except IDLE.
- acc_clear  output  1  one-cycle clear pulse to the accumulators.
- out_data  output  OUT_WIDTH  current lane value after width conversion.
- out_lane  output  max(1,$clog2(LANES))  index of the lane on out_data.
- out_valid  output  1  beat available.
- out_last  output  1  high with out_valid on the final lane.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (reset==0, async): state=IDLE; busy, acc_clear, out_valid and out_last = 0; out_data and out_lane = 0; shadow registers = 0. Takes effect immediately, including mid-drain. No acc_clear is issued on abort.
- States: IDLE, SEND, CLEAR.
- IDLE:
  - On the edge where start==1, all LANES values of acc_in are registered into shadow registers.
  - Lane index is set to 0 and state goes to SEND.
  - out_valid=1 with lane 0 data on the following cycle, so latency start -> first valid is 1 cycle.
- SEND:
  - out_valid is held high.
  - out_data, out_lane and out_last are stable while out_valid && !out_ready.
  - Handshake = out_valid && out_ready at the rising edge.
  - On a handshake with lane < LANES-1: lane increments and the next lane is presented the next cycle. Back-to-back beats are allowed, one per cycle with out_ready held high.
  - On a handshake with lane == LANES-1: out_valid drops next cycle and state goes to CLEAR.
- CLEAR:
  - acc_clear=1 for exactly one cycle, busy=1.
  - Then state goes to IDLE.
- start while busy (SEND or CLEAR) is ignored, not queued.
- acc_in changes after capture do not affect the beats being sent.
- out_last = out_valid && (lane == LANES-1).
- LANES==1: the single beat has out_last=1.
- out_lane is 0 when not valid.
- Width conversion (default, macro absent): out_data = low OUT_WIDTH bits of the lane value (truncation). If OUT_WIDTH==WIDTH, the value passes unchanged.
- Minimum drain duration: 1 capture cycle + LANES beat cycles + 1 clear cycle.

Optional Feature:
- Macro: ACCUM_DRAIN_SAT_EN.
- When defined:
  - Each lane is treated as signed WIDTH-bit.
  - out_data saturates to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Saturation is computed combinationally from the shadow register, so it adds no latency.
- When undefined: plain truncation as above, with no saturation logic compiled.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release -> busy=0, out_valid=0, acc_clear=0. Holding start=0 keeps it idle.
- Basic drain, out_ready=1, LANES=4, acc_in lanes = {10,20,30,40} -> start; next cycle beats 10,20,30,40 on consecutive cycles with out_lane 0..3; out_last only on 40; acc_clear one cycle later; busy low the cycle after.
- Backpressure: out_ready=0 for 3 cycles during lane 1 -> out_data=20, out_lane=1 held stable. Then out_ready=1 -> continues with 30, 40; total beats = 4, no duplicates.
- Snapshot isolation and start ignore: change acc_in to all 99 and pulse start during SEND -> remaining beats still carry the originally captured values; no second drain occurs.
- Reset mid-drain: assert reset=0 after the lane 1 handshake -> outputs drop to 0 immediately, no acc_clear. A new start afterwards drains fresh acc_in from lane 0.
- Width conversion, lane value 32'h0001_2345, OUT_WIDTH=16:
  - Without ACCUM_DRAIN_SAT_EN -> 16'h2345.
  - With ACCUM_DRAIN_SAT_EN -> 16'h7FFF.
  - With ACCUM_DRAIN_SAT_EN, lane -70000 -> 16'h8000.
